// File: rtl/vslc_scan_scheduler.sv
// rtl/vslc_scan_scheduler.sv - scan sequencer for the VSLC serial EEPROM program reader (optional SCAN_SCHED_COUNT_EN)
module vslc_scan_scheduler #(
    parameter int ADDR_W = 10,
    parameter int WDT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_auto,
    input  logic              trigger_in,
    input  logic [WDT_W-1:0]  wdt_limit,
    input  logic              rd_ready,
    input  logic [7:0]        rd_byte,
    input  logic [15:0]       rd_addr,
    output logic              restart,
    output logic [15:0]       restart_addr,
    output logic              hold_n,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr,
    output logic              instr_valid,
    output logic              scan_start,
    output logic              scan_done,
    output logic              fault
`ifdef SCAN_SCHED_COUNT_EN
    ,
    output logic [15:0]       scan_count,
    output logic              overrun
`endif
);

    typedef enum logic [1:0] {
        S_HDR,
        S_RUN,
        S_WAIT,
        S_FAULT
    } state_t;

    state_t           state;
    logic             restart_q;
    logic             scan_start_q;
    logic             boot_q;
    logic             pending;
    logic [WDT_W-1:0] wdt_cnt;
    logic             trig_s1;
    logic             trig_s2;
    logic             trig_s3;

    logic             trig_edge;
    logic [15:0]      start_ext;
    logic [15:0]      end_ext;
    logic             in_window;
    logic [ADDR_W-1:0] hdr_end_new;
    logic             hdr_bad;
    logic [WDT_W-1:0] wdt_inc;
    logic             wdt_clear;
    logic             wdt_trip;

    assign trig_edge = trig_s2 & ~trig_s3;
    assign start_ext = 16'(start_addr);
    assign end_ext   = 16'(end_addr);
    assign in_window = (rd_addr >= start_ext) && (rd_addr <= end_ext);

    // Byte qualification is combinational so the executor sees it alongside rd_byte
    assign instr_valid = rst_n && (state == S_RUN) && rd_ready && in_window;
    assign scan_done   = instr_valid && (rd_addr == end_ext);

    // The header fetch restart has to appear in the first cycle out of reset, hence the boot term
    assign restart    = restart_q | (boot_q & rst_n);
    assign scan_start = scan_start_q;

    // Header is judged on the end value being written this cycle, not the stale register
    assign hdr_end_new = {end_addr[ADDR_W-1:8], rd_byte};
    assign hdr_bad     = (hdr_end_new == '0) || (hdr_end_new < start_addr) ||
                         (start_addr < ADDR_W'(4));

    // Watchdog trips when the incremented count lands on the limit, so the fault
    // shows exactly wdt_limit cycles after the last byte
    assign wdt_inc   = (&wdt_cnt) ? wdt_cnt : wdt_cnt + {{(WDT_W-1){1'b0}}, 1'b1};
    assign wdt_clear = rd_ready | restart;
    assign wdt_trip  = (wdt_limit != '0) && !wdt_clear && (wdt_inc == wdt_limit);

    // Two-flop synchroniser plus edge register for the asynchronous trigger
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trigger_in;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    // Main sequencer: header fetch, scan loop, trigger wait, fault trap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_HDR;
            start_addr   <= '0;
            end_addr     <= '0;
            restart_addr <= '0;
            hold_n       <= 1'b1;
            fault        <= 1'b0;
            wdt_cnt      <= '0;
            pending      <= 1'b0;
            restart_q    <= 1'b0;
            scan_start_q <= 1'b0;
            boot_q       <= 1'b1;
        end else begin
            boot_q       <= 1'b0;
            restart_q    <= 1'b0;
            scan_start_q <= 1'b0;
            case (state)
                S_HDR: begin
                    wdt_cnt <= wdt_clear ? '0 : wdt_inc;
                    if (wdt_trip) begin
                        state  <= S_FAULT;
                        fault  <= 1'b1;
                        hold_n <= 1'b0;
                    end else if (rd_ready) begin
                        case (rd_addr)
                            16'd0: start_addr[ADDR_W-1:8] <= rd_byte[ADDR_W-9:0];
                            16'd1: start_addr[7:0]        <= rd_byte;
                            16'd2: end_addr[ADDR_W-1:8]   <= rd_byte[ADDR_W-9:0];
                            16'd3: begin
                                end_addr[7:0] <= rd_byte;
                                if (hdr_bad) begin
                                    state  <= S_FAULT;
                                    fault  <= 1'b1;
                                    hold_n <= 1'b0;
                                end else begin
                                    restart_q    <= 1'b1;
                                    scan_start_q <= 1'b1;
                                    restart_addr <= start_ext;
                                    state        <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    wdt_cnt <= wdt_clear ? '0 : wdt_inc;
                    if (wdt_trip) begin
                        state  <= S_FAULT;
                        fault  <= 1'b1;
                        hold_n <= 1'b0;
                    end else if (scan_done) begin
                        pending <= 1'b0;
                        if (mode_auto || pending || trig_edge) begin
                            restart_q    <= 1'b1;
                            scan_start_q <= 1'b1;
                        end else begin
                            state  <= S_WAIT;
                            hold_n <= 1'b0;
                        end
                    end else if (trig_edge) begin
                        pending <= 1'b1;
                    end
                end
                S_WAIT: begin
                    wdt_cnt <= '0;
                    if (trig_edge || mode_auto) begin
                        hold_n       <= 1'b1;
                        restart_q    <= 1'b1;
                        scan_start_q <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                default: begin
                    fault  <= 1'b1;
                    hold_n <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_SCHED_COUNT_EN
    // Scan statistics: completed scans and triggers lost to a full pending slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (scan_done) begin
                scan_count <= scan_count + 16'd1;
            end
            if ((state == S_RUN) && trig_edge && pending) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vslc_scan_scheduler.sv
// tb/tb_vslc_scan_scheduler.sv - directed self-checking bench for vslc_scan_scheduler
module tb_vslc_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_auto;
    logic        trigger_in;
    logic [15:0] wdt_limit;
    logic        rd_ready;
    logic [7:0]  rd_byte;
    logic [15:0] rd_addr;
    logic        restart;
    logic [15:0] restart_addr;
    logic        hold_n;
    logic [9:0]  start_addr;
    logic [9:0]  end_addr;
    logic        instr_valid;
    logic        scan_start;
    logic        scan_done;
    logic        fault;
`ifdef SCAN_SCHED_COUNT_EN
    logic [15:0] scan_count;
    logic        overrun;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vslc_scan_scheduler #(.ADDR_W(10), .WDT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_auto    (mode_auto),
        .trigger_in   (trigger_in),
        .wdt_limit    (wdt_limit),
        .rd_ready     (rd_ready),
        .rd_byte      (rd_byte),
        .rd_addr      (rd_addr),
        .restart      (restart),
        .restart_addr (restart_addr),
        .hold_n       (hold_n),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .instr_valid  (instr_valid),
        .scan_start   (scan_start),
        .scan_done    (scan_done),
        .fault        (fault)
`ifdef SCAN_SCHED_COUNT_EN
        ,
        .scan_count   (scan_count),
        .overrun      (overrun)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] b, output logic iv, output logic sd);
        rd_ready = 1'b1;
        rd_addr  = a;
        rd_byte  = b;
        #1;
        iv = instr_valid;
        sd = scan_done;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic header(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic iv, sd;
        send(16'd0, b0, iv, sd);
        send(16'd1, b1, iv, sd);
        send(16'd2, b2, iv, sd);
        send(16'd3, b3, iv, sd);
    endtask

    task automatic scan(input logic [15:0] s, input logic [15:0] e, output int n_iv, output int n_sd, output logic last_sd);
        logic iv, sd;
        n_iv = 0;
        n_sd = 0;
        last_sd = 1'b0;
        for (int a = int'(s); a <= int'(e); a++) begin
            send(16'(a), 8'(a), iv, sd);
            n_iv += int'(iv);
            n_sd += int'(sd);
            last_sd = sd;
        end
    endtask

    initial begin
        logic iv, sd, last_sd;
        int   n_iv, n_sd;

        rst_n = 1'b0; mode_auto = 1'b1; trigger_in = 1'b0; wdt_limit = 16'd0;
        rd_ready = 1'b0; rd_byte = 8'h00; rd_addr = 16'h0000;

        // reset values
        rst_n = 1'b0;
        step(); step();
        check("rst_restart", restart, 0);
        check("rst_hold_n", hold_n, 1);
        check("rst_fault", fault, 0);
        check("rst_start", start_addr, 0);
        check("rst_raddr", restart_addr, 0);
        check("rst_scan_start", scan_start, 0);
        rst_n = 1'b1;
        #1;
        check("boot_restart", restart, 1);

        // auto mode: header 00 10 00 13
        header(8'h00, 8'h10, 8'h00, 8'h13);
        check("hdr_restart", restart, 1);
        check("hdr_scan_start", scan_start, 1);
        check("hdr_raddr", restart_addr, 16'h0010);
        check("hdr_start", start_addr, 10'h010);
        check("hdr_end", end_addr, 10'h013);
        scan(16'h0010, 16'h0013, n_iv, n_sd, last_sd);
        check("auto_iv_count", 32'(n_iv), 4);
        check("auto_sd_count", 32'(n_sd), 1);
        check("auto_sd_last", last_sd, 1);
        check("auto_restart", restart, 1);
        check("auto_scan_start", scan_start, 1);
        send(16'h000F, 8'hAA, iv, sd);
        check("stale_iv", iv, 0);
        send(16'h0014, 8'hAA, iv, sd);
        check("beyond_end_iv", iv, 0);

        // manual mode: WAIT then trigger with three-cycle latency
        mode_auto = 1'b0;
        scan(16'h0010, 16'h0013, n_iv, n_sd, last_sd);
        check("man_sd", last_sd, 1);
        check("man_hold_n", hold_n, 0);
        check("man_restart", restart, 0);
        step(); step();
        check("wait_hold_n", hold_n, 0);
        trigger_in = 1'b1;
        step();
        check("trig_lat1", restart, 0);
        step();
        check("trig_lat2", restart, 0);
        step();
        check("trig_lat3", restart, 1);
        check("trig_hold_n", hold_n, 1);
        check("trig_scan_start", scan_start, 1);
        trigger_in = 1'b0;
        step();

        // trigger during RUN becomes pending: no WAIT entry
        send(16'h0010, 8'h00, iv, sd);
        trigger_in = 1'b1;
        send(16'h0011, 8'h00, iv, sd);
        step(); step();
        trigger_in = 1'b0;
        send(16'h0012, 8'h00, iv, sd);
        send(16'h0013, 8'h00, iv, sd);
        check("pend_sd", sd, 1);
        check("pend_restart", restart, 1);
        check("pend_hold_n", hold_n, 1);
        step();
        check("pend_cleared_hold", hold_n, 1);
        scan(16'h0010, 16'h0013, n_iv, n_sd, last_sd);
        check("pend_then_wait", hold_n, 0);

        // bad headers
        mode_auto = 1'b1;
        do_reset(1);
        header(8'h00, 8'h10, 8'h00, 8'h00);
        check("end0_fault", fault, 1);
        check("end0_hold_n", hold_n, 0);
        check("end0_restart", restart, 0);
        step();
        check("end0_sticky", fault, 1);
        do_reset(1);
        check("fault_cleared", fault, 0);
        header(8'h00, 8'h20, 8'h00, 8'h10);
        check("rev_fault", fault, 1);
        do_reset(1);
        header(8'h00, 8'h03, 8'h00, 8'h10);
        check("low_start_fault", fault, 1);
        do_reset(1);
        header(8'h00, 8'h04, 8'h00, 8'h04);
        check("edge_hdr_fault", fault, 0);
        check("edge_hdr_restart", restart, 1);
        do_reset(1);
        header(8'hFD, 8'h20, 8'hFE, 8'h30);
        check("hi_mask_start", start_addr, 10'h120);
        check("hi_mask_end", end_addr, 10'h230);

        // watchdog at limit 8
        wdt_limit = 16'd8;
        do_reset(1);
        header(8'h00, 8'h10, 8'h00, 8'h13);
        send(16'h0010, 8'h00, iv, sd);
        send(16'h0011, 8'h00, iv, sd);
        for (int k = 1; k < 8; k++) begin
            check("wdt_early", fault, 0);
            step();
        end
        check("wdt_pre", fault, 0);
        step();
        check("wdt_fault", fault, 1);
        check("wdt_hold_n", hold_n, 0);

        // watchdog disabled
        wdt_limit = 16'd0;
        do_reset(1);
        header(8'h00, 8'h10, 8'h00, 8'h13);
        send(16'h0010, 8'h00, iv, sd);
        for (int k = 0; k < 30; k++) step();
        check("wdt_off_fault", fault, 0);
        scan(16'h0011, 16'h0013, n_iv, n_sd, last_sd);
        check("wdt_off_sd", last_sd, 1);

        // reset mid-scan
        mode_auto = 1'b1;
        do_reset(1);
        header(8'h00, 8'h10, 8'h00, 8'h13);
        send(16'h0010, 8'h00, iv, sd);
        send(16'h0011, 8'h00, iv, sd);
        rst_n = 1'b0;
        rd_ready = 1'b1;
        rd_addr  = 16'h0012;
        #1;
        check("mid_rst_iv", instr_valid, 0);
        check("mid_rst_restart", restart, 0);
        step();
        rd_ready = 1'b0;
        check("mid_rst_start", start_addr, 0);
        check("mid_rst_raddr", restart_addr, 0);
        check("mid_rst_hold_n", hold_n, 1);
`ifdef SCAN_SCHED_COUNT_EN
        check("mid_rst_count", scan_count, 0);
`endif
        rst_n = 1'b1;
        #1;
        check("mid_rst_boot", restart, 1);
        header(8'h00, 8'h20, 8'h00, 8'h24);
        check("refetch_start", start_addr, 10'h020);
        check("refetch_raddr", restart_addr, 16'h0020);
        scan(16'h0020, 16'h0024, n_iv, n_sd, last_sd);
        check("refetch_iv", 32'(n_iv), 5);
`ifdef SCAN_SCHED_COUNT_EN
        check("count_one", scan_count, 1);
        check("overrun_clear", overrun, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vslc_scan_scheduler.md
Name: vslc_scan_scheduler

Overview:
Controls the sequencing of the serial EEPROM program reader for the VSLC PLC core.
- On reset it fetches the 4-byte program header (start/end address).
- It then repeatedly restarts the reader at the program start, so the executor sees one instruction stream per scan cycle.
- Scans run back-to-back (auto mode) or one per external trigger (manual mode).
- It pauses the reader via HOLD between triggered scans, and drops to a fault state on a bad header or a stalled reader.

Parameters:
ADDR_W, 10, width of program start/end addresses (header bytes 0/2 supply bits [ADDR_W-1:8]).
WDT_W, 16, width of the byte-arrival watchdog counter.

Ports:
clk  input  1  single core clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
mode_auto  input  1  1 = restart immediately after each scan; 0 = wait for trigger.
trigger_in  input  1  asynchronous scan trigger; double-flop synchronised internally, rising edge used.
wdt_limit  input  WDT_W  max clk cycles between reader bytes; 0 disables watchdog.
rd_ready  input  1  reader byte-valid pulse (one cycle per byte).
rd_byte  input  8  byte from reader.
rd_addr  input  16  address of rd_byte.
restart  output  1  one-cycle pulse: reader reloads restart_addr and begins reading.
restart_addr  output  16  address the reader restarts from.
hold_n  output  1  active-low reader pause.
start_addr  output  ADDR_W  program start from header.
end_addr  output  ADDR_W  program end (inclusive) from header.
instr_valid  output  1  rd_byte is a program instruction for the executor.
scan_start  output  1  one-cycle pulse at scan begin (executor latches inputs).
scan_done  output  1  one-cycle pulse when the end_addr byte is delivered.
fault  output  1  sticky error flag.

Behaviour:
- States: HDR, RUN, WAIT, FAULT.
- Reset (rst_n=0 at posedge): state HDR, start/end_addr=0, restart_addr=0, hold_n=1, fault=0, watchdog=0, pending=0.
  - restart/scan_start/scan_done/instr_valid are 0 during reset.
  - restart pulses in the first cycle after reset deasserts.
- HDR:
  - On rd_ready, capture by rd_addr: 0 → start[ADDR_W-1:8]; 1 → start[7:0]; 2 → end[ADDR_W-1:8]; 3 → end[7:0].
  - Upper-byte bits beyond ADDR_W-8 are ignored. instr_valid=0 throughout.
  - After the byte at addr 3, validate using the new end value.
    - Fault: end==0, or end<start, or start<4 → FAULT.
    - Otherwise, next cycle: restart=1, restart_addr={0,start}, scan_start=1, state RUN.
- RUN:
  - instr_valid=rd_ready while start ≤ rd_addr ≤ end. Bytes outside that window (stale bytes after restart) are ignored.
  - On rd_ready with rd_addr==end: instr_valid=1 and scan_done=1 in that same cycle.
  - Next cycle after scan_done:
    - If mode_auto=1 or pending=1: restart+scan_start pulse, stay RUN, clear pending.
    - Otherwise: state WAIT, hold_n=0.
- WAIT: hold_n=0. On synchronised trigger rising edge: hold_n=1, restart+scan_start pulse, state RUN.
  - Latency is 3 clk from raw trigger edge to restart: 2 sync + 1 edge register.
  - mode_auto going 1 while in WAIT also restarts on the next cycle.
- Trigger edge during RUN sets pending (one-deep; extra edges dropped).
- Trigger edge in the same cycle as scan_done counts as pending.
- Watchdog (HDR/RUN only):
  - The counter clears on rd_ready or restart, and increments otherwise, saturating.
  - When wdt_limit≠0 and counter==wdt_limit → FAULT.
  - Frozen and cleared in WAIT.
- FAULT: fault=1, hold_n=0, no pulses, header regs retained. Exit only via reset.
- Reset asserted mid-scan: aborts immediately, same as power-on. Header is re-fetched.
- Address compares are unsigned, with rd_addr zero-extended vs {0,start/end}.

Optional Feature:
SCAN_SCHED_COUNT_EN
- Defined: adds output scan_count [15:0], reset 0, incremented on every scan_done, wrapping 0xFFFF→0.
- Also adds output overrun [0:0], sticky, set when a trigger edge arrives while pending is already 1.
- Not defined: neither port exists and no counter logic is built.

Test Plan:
- Header bytes 00,10,00,13 at addr 0–3, mode_auto=1 → restart with restart_addr=0x10, scan_start. Bytes 0x10–0x13 give 4 instr_valid; scan_done on 0x13; restart next cycle.
- Same header, mode_auto=0 → after scan_done, hold_n=0 in WAIT. Trigger rise → restart exactly 3 clk later, hold_n=1.
- Trigger pulse while RUN at addr 0x11, mode_auto=0 → no WAIT entry; restart the cycle after scan_done.
- Header end=0x0000 → fault=1, hold_n=0 after addr-3 byte. Header start=0x20,end=0x10 → fault.
- wdt_limit=8, stop rd_ready mid-RUN → fault asserts 8 cycles after the last byte. wdt_limit=0, same stall → no fault.
- Assert rst_n=0 mid-scan for 1 cycle → all outputs at reset values, restart with addr 0, header re-captured. With SCAN_SCHED_COUNT_EN, scan_count returns to 0.
